// File: rtl/mario_sprite_pkg.sv
// Shared geometry, key colour and animation types for the Mario sprite fetch path.
package mario_sprite_pkg;

    localparam int SPRITE_W      = 21;
    localparam int SPRITE_H      = 21;
    localparam int SPRITE_ADDR_W = 9;
    localparam int WALK_PERIOD   = 8;
    localparam int WALK_CNT_W    = $clog2(WALK_PERIOD);

    localparam logic [23:0] TRANSPARENT_KEY = 24'h800080;

    typedef enum logic [1:0] {
        STILL  = 2'd0,
        WALK_A = 2'd1,
        WALK_B = 2'd2,
        JUMP   = 2'd3
    } anim_state_t;

    // Row-major ROM address inside the sprite box; max 20*21+20 = 440.
    function automatic logic [SPRITE_ADDR_W-1:0] sprite_addr(
        input logic [4:0] row,
        input logic [4:0] col
    );
        logic [SPRITE_ADDR_W-1:0] addr;
        addr = SPRITE_ADDR_W'(row) * SPRITE_ADDR_W'(SPRITE_W) + SPRITE_ADDR_W'(col);
        return addr;
    endfunction

endpackage

// File: rtl/mario_anim_fsm.sv
// Per-frame animation state machine: STILL / WALK_A / WALK_B / JUMP, advanced on frame_start.
module mario_anim_fsm
    import mario_sprite_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_start,
    input  logic        moving,
    input  logic        airborne,
    output anim_state_t state
);

    anim_state_t             state_reg, state_next;
    logic [WALK_CNT_W-1:0]   walk_cnt_reg, walk_cnt_next;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg    <= STILL;
            walk_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            walk_cnt_reg <= walk_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        walk_cnt_next = walk_cnt_reg;
        if (frame_start) begin
            if (airborne) begin
                state_next = JUMP;
            end else if (!moving) begin
                state_next    = STILL;
                walk_cnt_next = '0;
            end else if (state_reg == STILL || state_reg == JUMP) begin
                state_next    = WALK_A;
                walk_cnt_next = '0;
            end else begin
                walk_cnt_next = walk_cnt_reg + 1'b1;
                // Swap walk frames every WALK_PERIOD frames, on the counter wrap.
                if (walk_cnt_reg == WALK_CNT_W'(WALK_PERIOD - 1)) begin
                    state_next = (state_reg == WALK_A) ? WALK_B : WALK_A;
                end
            end
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/mario_sprite_fetch.sv
// Two-stage sprite ROM front end: box test + address/bank select, then hit/colour with magenta keyed out.
// Optional MARIO_SPRITE_MIRROR_EN: mirror columns for left-facing Mario instead of using a separate ROM bank.
module mario_sprite_fetch
    import mario_sprite_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_start,
    input  logic        pixel_valid,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  Mario_X,
    input  logic [9:0]  Mario_Y,
    input  logic        facing_left,
    input  logic        moving,
    input  logic        airborne,
    output logic [8:0]  read_address,
    output logic [2:0]  sprite_sel,
    input  logic [23:0] rom_color,
    output logic        out_valid,
    output logic        sprite_hit,
    output logic [23:0] sprite_color
);

    anim_state_t anim_state;

    mario_anim_fsm u_anim_fsm (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .moving      (moving),
        .airborne    (airborne),
        .state       (anim_state)
    );

    logic face_q_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            face_q_reg <= 1'b0;
        end else if (frame_start) begin
            face_q_reg <= facing_left;
        end
    end

    // Axis 0 is X (width), axis 1 is Y (height); 11-bit math keeps origin+extent from wrapping.
    logic [1:0][10:0] beam_ext;
    logic [1:0][10:0] origin_ext;
    logic [1:0][4:0]  offset;
    logic [1:0]       axis_hit;

    assign beam_ext[0]   = {1'b0, DrawX};
    assign beam_ext[1]   = {1'b0, DrawY};
    assign origin_ext[0] = {1'b0, Mario_X};
    assign origin_ext[1] = {1'b0, Mario_Y};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            localparam int EXTENT = (gi == 0) ? SPRITE_W : SPRITE_H;
            assign axis_hit[gi] = (beam_ext[gi] >= origin_ext[gi]) &&
                                  (beam_ext[gi] <  origin_ext[gi] + 11'(EXTENT));
            assign offset[gi]   = 5'(beam_ext[gi] - origin_ext[gi]);
        end
    endgenerate

    logic                     in_box;
    logic [4:0]               col_eff;
    logic                     face_bank;
    logic [SPRITE_ADDR_W-1:0] addr_next;
    logic [2:0]               sel_next;

    assign in_box = &axis_hit;

`ifdef MARIO_SPRITE_MIRROR_EN
    assign col_eff   = face_q_reg ? (5'(SPRITE_W - 1) - offset[0]) : offset[0];
    assign face_bank = 1'b0;
`else
    assign col_eff   = offset[0];
    assign face_bank = face_q_reg;
`endif

    assign addr_next = in_box ? sprite_addr(offset[1], col_eff) : '0;
    // Uses the pre-update FSM/face state when frame_start coincides with a pixel.
    assign sel_next  = {face_bank, anim_state};

    logic                     in_box_s1_reg;
    logic                     valid_s1_reg;
    logic [SPRITE_ADDR_W-1:0] addr_s1_reg;
    logic [2:0]               sel_s1_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            in_box_s1_reg <= 1'b0;
            valid_s1_reg  <= 1'b0;
            addr_s1_reg   <= '0;
            sel_s1_reg    <= '0;
        end else begin
            in_box_s1_reg <= in_box;
            valid_s1_reg  <= pixel_valid;
            addr_s1_reg   <= addr_next;
            sel_s1_reg    <= sel_next;
        end
    end

    logic        hit_next;
    logic        out_valid_reg;
    logic        hit_reg;
    logic [23:0] color_reg;

    assign hit_next = valid_s1_reg && in_box_s1_reg && (rom_color != TRANSPARENT_KEY);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid_reg <= 1'b0;
            hit_reg       <= 1'b0;
            color_reg     <= '0;
        end else begin
            out_valid_reg <= valid_s1_reg;
            hit_reg       <= hit_next;
            color_reg     <= hit_next ? rom_color : 24'h0;
        end
    end

    assign read_address = addr_s1_reg;
    assign sprite_sel   = sel_s1_reg;
    assign out_valid    = out_valid_reg;
    assign sprite_hit   = hit_reg;
    assign sprite_color = color_reg;

endmodule

// File: doc/mario_sprite_fetch.md
# mario_sprite_fetch

Pipelined front end for Mario's sprite ROMs. Per pixel it decides whether the beam (DrawX, DrawY) lies inside Mario's 21x21 bounding box, forms the 9-bit ROM read address, and selects the ROM bank from an animation state machine advanced once per frame. It returns the palette colour with a hit flag, with magenta treated as transparent, to the colour mapper.

## Interface
- Parameters: none. Geometry and key colour come from `mario_sprite_pkg`.
- `Clk` in 1: system clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse per frame (vsync edge).
- `pixel_valid` in 1: DrawX/DrawY valid this cycle.
- `DrawX`, `DrawY` in 10 each: beam position.
- `Mario_X`, `Mario_Y` in 10 each: top-left of sprite, sampled every cycle.
- `facing_left`, `moving`, `airborne` in 1 each: motion flags, sampled on `frame_start`.
- `read_address` out 9: to sprite ROM, registered.
- `sprite_sel` out 3: ROM bank select, registered. Bits [1:0] are the animation state; bit [2] is the facing bank (see Configuration).
- `rom_color` in 24: combinational ROM palette output.
- `out_valid` out 1: `sprite_hit`/`sprite_color` correspond to a pixel.
- `sprite_hit` out 1: opaque sprite pixel.
- `sprite_color` out 24: colour when hit, else 0.

## Operation
- In-box test uses 11-bit zero-extended arithmetic, so there is no wrap:
  - `DrawX >= Mario_X && DrawX < Mario_X+21`
  - `DrawY >= Mario_Y && DrawY < Mario_Y+21`
- Address = `dy*21 + col`, where `dy = DrawY-Mario_Y` and `col = DrawX-Mario_X` (mirrored: `20-col`).
  - Range is 0..440; it fits in 9 bits.
  - When out of box, `read_address` = 0.
- Animation FSM (sub-module) has states STILL=0, WALK_A=1, WALK_B=2, JUMP=3. It updates only on `frame_start`:
  - `airborne` → JUMP. This has priority.
  - Else `!moving` → STILL; `walk_cnt` is cleared.
  - Else, if the state is STILL or JUMP → WALK_A with `walk_cnt`=0.
  - Else `walk_cnt` (3-bit) increments. When it wraps 7→0, the state toggles WALK_A↔WALK_B.
- `facing_left` is latched on `frame_start` into `face_q`.
- Stage 1 registers: `in_box`, `pixel_valid`, `read_address`, `sprite_sel`.
- Stage 2 registers:
  - `out_valid` ← stage-1 valid.
  - `sprite_hit` ← stage-1 valid && `in_box` && `rom_color != 24'h800080`.
  - `sprite_color` ← `rom_color` if hit, else 0.
- When `pixel_valid`=0: stage 1 still advances. `out_valid`=0 and `sprite_hit`=0 for that slot.
- A box extending past X=639 or Y=479 needs no special handling; pixels beyond those limits are never drawn.

## Timing
- Latency is 2 cycles: inputs at edge N produce `read_address` after edge N+1 and `sprite_hit`/`sprite_color` after edge N+2. Throughput is 1 pixel/cycle.
- There is no back-pressure.
- `frame_start` and `pixel_valid` in the same cycle: that pixel uses the pre-update state. The new `sprite_sel` applies from the next cycle's stage-1 capture.
- Reset values (all outputs and state):
  - Outputs: `read_address`=0, `sprite_sel`=0, `out_valid`=0, `sprite_hit`=0, `sprite_color`=0.
  - State: FSM=STILL, `walk_cnt`=0, `face_q`=0.
- Reset asserted mid-frame clears the pipeline at once. In-flight pixels are dropped; nothing is replayed.

## Configuration
- `MARIO_SPRITE_MIRROR_EN` defined:
  - `face_q`=1 mirrors the column (`col' = 20-col`), so the right-facing ROMs serve both directions.
  - `sprite_sel[2]` is forced to 0.
- Undefined:
  - No mirroring.
  - `sprite_sel[2]` = `face_q`; the colour mapper selects dedicated left-facing ROMs.

## Structure
- `mario_sprite_pkg` holds:
  - `SPRITE_W`=21, `SPRITE_H`=21, `SPRITE_ADDR_W`=9.
  - `TRANSPARENT_KEY`=24'h800080.
  - `anim_state_t` enum (STILL, WALK_A, WALK_B, JUMP) and `WALK_PERIOD`=8.
- One sub-module, `mario_anim_fsm`:
  - Inputs: `Clk`, `Reset_n`, `frame_start`, `moving`, `airborne`.
  - Output: `anim_state_t` state.

## Test plan
- Mario=(100,200), beam (100,200) then (120,220), ROM model with no magenta at those addresses → `read_address` 0 then 440; `sprite_hit`=1 two cycles after each input.
- Beam (99,200) and (121,200) → `sprite_hit`=0, `read_address`=0, `out_valid`=1.
- ROM returns 24'h800080 at address 25, beam (104,201) → `sprite_hit`=0, `sprite_color`=0.
- `moving`=1 for 17 `frame_start` pulses → state WALK_A for pulses 1–8, WALK_B for 9–16, WALK_A at 17. Asserting `airborne` on the next pulse → JUMP.
- With the macro and `facing_left`=1 latched, beam (100,200) → `read_address`=20; without the macro → `read_address`=0 and `sprite_sel[2]`=1.
- `Reset_n` pulsed low mid-row with pixels in flight → all outputs 0 immediately and FSM=STILL; the first valid pixel after release appears 2 cycles later.
